sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Memory-stage block directly downstream of the ALU. It takes the ALU result as a byte address, plus the store value.
- Serves LDR/STR on the off-chip 16-bit asynchronous SRAM, as two half-word accesses per 32-bit word.
- Drives `ready` low while busy so the pipeline freezes until the access completes.

Parameters:
- `ACCESS_CYCLES`, 3: cycles per half-word phase. Minimum 2.
- `MEM_BASE`, 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rd_en`  input  1  load request from the memory stage.
- `wr_en`  input  1  store request from the memory stage.
- `address`  input  32  byte address (ALU result).
- `st_val`  input  32  store data.
- `read_data`  output  32  load result.
- `ready`  output  1  1 = no access pending, or access completes this cycle.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  output  18  SRAM half-word address.
- `SRAM_WE_N`  output  1  write enable, active-low.
- `SRAM_OE_N`  output  1  output enable, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  output  1  tied 0.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE, `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z.
  - Internal address/data latches and phase counter = 0.
  - Reset asserted mid-access aborts the access immediately. There is no partial-write recovery; the first cycle after reset release is IDLE.
- Address mapping:
  - off = `address` − `MEM_BASE`, computed mod 2^32.
  - word = off[18:2], so the address wraps within 128K words. off[1:0] is ignored (word-aligned only).
  - Low phase: `SRAM_ADDR` = {word,0}. High phase: `SRAM_ADDR` = {word,1}.
- Request rules:
  - `req` = `rd_en` | `wr_en`.
  - `rd_en` and `wr_en` both high: treated as a write.
  - Requester holds `rd_en`/`wr_en`/`address`/`st_val` stable until `ready`=1. Values are latched on leaving IDLE regardless.
- `ready` (combinational):
  - 1 when state=IDLE and `req`=0.
  - 1 when state=DONE.
  - 0 otherwise, including the IDLE cycle in which `req` first rises.
- FSM, counter `cnt` in 0..`ACCESS_CYCLES`−1:
  - IDLE: `req` → LO, `cnt`=0, latch address/data/op. Otherwise stay.
  - LO: `cnt` increments each cycle. At `cnt`=`ACCESS_CYCLES`−1 → HI, `cnt`=0.
  - HI: same counting. At `cnt`=`ACCESS_CYCLES`−1 → DONE.
  - DONE: one cycle with `ready`=1 → IDLE unconditionally.
  - A request still high in the following IDLE cycle is a new access; the pipeline advanced at the DONE edge.
- Latency:
  - Request first seen in cycle 0; `ready`=1 in cycle 2·`ACCESS_CYCLES`+1 (7 at default).
  - Back-to-back accesses: 2·`ACCESS_CYCLES`+2 cycles apart.
- Write, per phase:
  - `SRAM_DQ` driven with the latched st_val[15:0] in LO, st_val[31:16] in HI, for the whole phase.
  - `SRAM_WE_N`=0 for `cnt` < `ACCESS_CYCLES`−1 and 1 on the last cycle, so data/address hold past the WE_N rising edge.
  - `SRAM_OE_N`=1 throughout.
- Read, per phase:
  - `SRAM_DQ`=Z, `SRAM_OE_N`=0, `SRAM_WE_N`=1.
  - On the clock edge ending the last cycle of LO, `read_data`[15:0] ← `SRAM_DQ`. Same for HI into [31:16].
  - `read_data` is valid in DONE and held until the next read overwrites it. Writes never change it.
- IDLE/DONE: `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z; `SRAM_ADDR` holds its last value.
- `SRAM_DQ` is never driven while `SRAM_OE_N`=0.

Test Plan:
- Reset: `rst_n`=0 for 2 cycles → `ready`=1, `read_data`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z. Release with `req`=0 → `ready` stays 1.
- Store: `wr_en`=1, `address`=1024+8, `st_val`=0xDEADBEEF.
  - `SRAM_ADDR`=4 with `SRAM_DQ`=0xBEEF, then `SRAM_ADDR`=5 with `SRAM_DQ`=0xDEAD.
  - `SRAM_WE_N` low 2 cycles then high 1 cycle in each phase.
  - `ready`=1 exactly 7 cycles after the request.
- Load: `rd_en`=1, `address`=1032 against the SRAM model holding the word above → `read_data`=0xDEADBEEF in the DONE cycle, `ready`=1 at cycle 7, `SRAM_DQ` never driven by the DUT.
- Contention and wrap:
  - `rd_en`=`wr_en`=1 → behaves as a write; `read_data` unchanged.
  - `address`=1020 → off=0xFFFFFFFC, `SRAM_ADDR` uses word 0x1FFFF (halves 0x3FFFE/0x3FFFF).
- Back-to-back: a load held high through DONE → second access starts in the next IDLE cycle; second `ready` pulse 8 cycles after the first.
- Mid-access reset: assert `rst_n`=0 during HI of a write → `SRAM_WE_N`=1 and `SRAM_DQ`=Z immediately (async). After release: IDLE, `ready` follows `req`.

Source files
------------

// File: rtl/sram_controller.sv
// Memory-stage controller: 32-bit loads/stores as two 16-bit phases
// on an asynchronous SRAM, freezing the pipeline via ready while busy.
module sram_controller #(
    parameter int ACCESS_CYCLES = 3,
    parameter int MEM_BASE      = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] st_val,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   word_q, word_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [17:0]   sram_addr_q, sram_addr_d;

    logic [31:0] off;
    logic        req;
    logic        last;
    logic        active;
    logic [15:0] dq_out;
    logic        unused_off;

    assign off        = address - 32'(MEM_BASE);
    assign req        = rd_en | wr_en;
    assign last       = (cnt_q == CNT_LAST);
    assign unused_off = ^{off[31:19], off[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rd_data_d   = rd_data_q;
        sram_addr_d = sram_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d     = S_LO;
                    cnt_d       = '0;
                    word_d      = off[18:2];
                    data_d      = st_val;
                    wr_d        = wr_en;
                    sram_addr_d = {off[18:2], 1'b0};
                end
            end
            S_LO: begin
                if (last) begin
                    state_d     = S_HI;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    if (!wr_q) rd_data_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HI: begin
                if (last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!wr_q) rd_data_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            rd_data_q   <= rd_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    assign active = (state_q == S_LO) | (state_q == S_HI);
    assign dq_out = (state_q == S_HI) ? data_q[31:16] : data_q[15:0];

    // WE_N rises one cycle before the phase ends so data/address hold past it
    assign SRAM_WE_N = ~(active & wr_q & ~last);
    assign SRAM_OE_N = ~(active & ~wr_q);
    assign SRAM_DQ   = (active & wr_q) ? dq_out : 16'bz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign read_data = rd_data_q;
    assign ready     = ((state_q == S_IDLE) & ~req) | (state_q == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM device model, per-cycle
// reference model of the access timeline, and directed vectors.
module tb_sram_controller;

    localparam int AC   = 3;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] address, st_val;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_controller #(.ACCESS_CYCLES(AC), .MEM_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .st_val(st_val), .read_data(read_data),
        .ready(ready), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Asynchronous SRAM device
    logic [15:0] mem [0:(1<<18)-1];
    assign dq = (!oe_n && rst_n) ? mem[sram_addr] : 16'bz;
    always @(posedge we_n) if (rst_n) mem[sram_addr] <= dq;

    // Reference model: access timeline by cycle offset k from request
    logic [15:0] ref_mem [int];
    bit          m_busy = 0;
    int          m_k = 0;
    bit          m_wr = 0;
    logic [16:0] m_word = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rd = '0;
    logic [17:0] m_last_addr = '0;

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
    endfunction

    always @(negedge clk) begin
        logic        e_ready, e_we, e_oe, hi;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        logic [31:0] nxt_rd;
        int          idx;
        nxt_rd = m_rd;
        if (!rst_n) begin
            m_busy = 0; m_rd = '0; m_last_addr = '0; nxt_rd = '0;
            e_ready = !(rd_en | wr_en); e_we = 1; e_oe = 1; e_addr = '0;
        end else if (!m_busy) begin
            e_ready = !(rd_en | wr_en); e_we = 1; e_oe = 1;
            e_addr = m_last_addr;
            if (rd_en | wr_en) begin
                m_wr = wr_en;
                m_word = 17'((address - 32'(BASE)) >> 2);
                m_data = st_val;
                m_busy = 1;
                m_k = 1;
            end
        end else if (m_k <= 2 * AC) begin
            hi = (m_k > AC);
            idx = hi ? m_k - AC - 1 : m_k - 1;
            e_addr = {m_word, hi};
            m_last_addr = e_addr;
            e_ready = 0;
            if (m_wr) begin
                e_we = (idx < AC - 1) ? 1'b0 : 1'b1;
                e_oe = 1;
                e_dq = hi ? m_data[31:16] : m_data[15:0];
                chk("dq_write", 32'(dq), 32'(e_dq));
                if (idx == AC - 1) ref_mem[int'(e_addr)] = e_dq;
            end else begin
                e_we = 1; e_oe = 0;
                if (idx == AC - 1) begin
                    if (hi) nxt_rd[31:16] = ref_rd(e_addr);
                    else nxt_rd[15:0] = ref_rd(e_addr);
                end
            end
            m_k++;
        end else begin
            e_ready = 1; e_we = 1; e_oe = 1; e_addr = m_last_addr;
            m_busy = 0;
        end
        chk("ready", 32'(ready), 32'(e_ready));
        chk("we_n", 32'(we_n), 32'(e_we));
        chk("oe_n", 32'(oe_n), 32'(e_oe));
        chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        chk("read_data", read_data, m_rd);
        chk("ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'(0));
        m_rd = nxt_rd;
    end

    logic [17:0] addr_log [0:63];
    logic [15:0] dq_log   [0:63];
    logic        we_log   [0:63];
    logic [31:0] rd_log   [0:63];

    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] v,
                              output int lat);
        int k;
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; st_val = v;
        k = 0;
        lat = -1;
        while (k < 40) begin
            @(negedge clk);
            addr_log[k] = sram_addr; dq_log[k] = dq;
            we_log[k] = we_n; rd_log[k] = read_data;
            if (ready) begin
                lat = k;
                break;
            end
            k++;
        end
        if (lat < 0) chk("timeout", 32'(1), 32'(0));
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
    endtask

    initial begin
        int lat, t1, t2, n;
        for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0;
        rst_n = 0; rd_en = 0; wr_en = 0; address = '0; st_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_we_n", 32'(we_n), 32'(1));
        chk("rst_oe_n", 32'(oe_n), 32'(1));
        chk("rst_addr", 32'(sram_addr), 32'(0));
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rel_ready", 32'(ready), 32'(1));

        run_access(0, 1, 32'd1032, 32'hDEADBEEF, lat);
        chk("st_latency", 32'(lat), 32'd7);
        chk("st_lo_addr", 32'(addr_log[1]), 32'd4);
        chk("st_lo_dq", 32'(dq_log[1]), 32'hBEEF);
        chk("st_lo_we", 32'({we_log[1], we_log[2], we_log[3]}), 32'b001);
        chk("st_hi_addr", 32'(addr_log[4]), 32'd5);
        chk("st_hi_dq", 32'(dq_log[4]), 32'hDEAD);
        chk("st_hi_we", 32'({we_log[4], we_log[5], we_log[6]}), 32'b001);

        run_access(1, 0, 32'd1032, 32'h0, lat);
        chk("ld_latency", 32'(lat), 32'd7);
        chk("ld_data", rd_log[7], 32'hDEADBEEF);

        run_access(1, 1, 32'd1040, 32'h12345678, lat);
        chk("both_keeps_rd", rd_log[7], 32'hDEADBEEF);
        chk("both_wrote", 32'({mem[9], mem[8]}), 32'h12345678);
        run_access(1, 0, 32'd1040, 32'h0, lat);
        chk("both_readback", rd_log[7], 32'h12345678);

        run_access(0, 1, 32'd1020, 32'hCAFEF00D, lat);
        chk("wrap_lo_addr", 32'(addr_log[1]), 32'h3FFFE);
        chk("wrap_hi_addr", 32'(addr_log[4]), 32'h3FFFF);
        run_access(1, 0, 32'd1020, 32'h0, lat);
        chk("wrap_readback", rd_log[7], 32'hCAFEF00D);

        // Load held through DONE: second access follows immediately
        @(posedge clk); #1;
        rd_en = 1; address = 32'd1032;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 40);
        t1 = cyc;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 40);
        t2 = cyc;
        chk("b2b_spacing", 32'(t2 - t1), 32'd8);
        chk("b2b_data", read_data, 32'hDEADBEEF);
        @(posedge clk); #1 rd_en = 0;

        // Reset during the write-enable window of the HI phase
        @(posedge clk); #1;
        wr_en = 1; address = 32'd1048; st_val = 32'hA5A55A5A;
        repeat (AC + 2) @(posedge clk);
        #2;
        chk("mid_we_low", 32'(we_n), 32'(0));
        rst_n = 0;
        #1;
        chk("mid_we_n", 32'(we_n), 32'(1));
        chk("mid_oe_n", 32'(oe_n), 32'(1));
        wr_en = 0;
        #1;
        chk("mid_ready", 32'(ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'(1));
        run_access(1, 0, 32'd1048, 32'h0, lat);
        chk("partial_low", rd_log[7], 32'h00005A5A);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
